deparser: RTL and testbench
===========================

DEPARSER -- requirements
Module: deparser

Interface
REQ-001 Constants (shared definitions, no module parameters): NUM_HEADERS = 2, header count; NEXT_TABLE_SIZE = 2, next-table entries per header; NO_HEADER, marker for an absent header; WORD_WIDTH = 32, data word width.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  async active-high reset.
REQ-005 start_i  in  1  request to deparse one packet; level, held until ready_o is seen.
REQ-006 parsed_hdrs_i  in  2x32  {hdr0 addr, hdr1 addr}, in parser output order; NO_HEADER means absent.
REQ-007 mem_ce_o, mem_we_o  out  1 each  memory enable and write enable.
REQ-008 mem_addr_o  out  ADDR_BUS  byte address of the write.
REQ-009 mem_width_o  out  4  write width in bytes (1..4).
REQ-010 mem_data_o  out  32  write data, right-aligned.
REQ-011 ready_o  out  1  packet done.
REQ-012 err_o  out  1  a required tag had no table entry.
REQ-013 mod_start_i, mod_hdr_id_i, mod_hdr_len_i, mod_next_tag_start_i, mod_next_tag_len_i  in  1/32/32/32/32  configuration write, same meaning as the parser configuration port.
REQ-014 mod_next_table_i  in  64  entry0 = [63:32], entry1 = [31:0]; each entry has a NEXT_TAG_VAL field and a NEXT_HDR_ID field at the shared positions.

Function
REQ-015 The block shall hold per-header config: next_tag_start, next_tag_len, and next_table[2].
REQ-016 Config shall be written only in FREE when mod_start_i=1; mod_start_i has priority over start_i in the same cycle.
REQ-017 States shall be FREE, TAG0, TAG1 and DONE.
REQ-018 FREE with start_i=1 and mod_start_i=0 shall latch parsed_hdrs_i, clear err_o, deassert ready_o, and go to TAG0.
REQ-019 TAG(i) next-id rule: if i=0 and hdr1 is present, next id = 1; otherwise the header is last and no tag is written.
REQ-020 Lookup: search next_table[i] entry0 first, then entry1, for NEXT_HDR_ID == next id; the first match supplies the tag value.
REQ-021 Write in TAG(i), asserted for exactly one cycle: ce=1, we=1, addr = hdr(i) addr + next_tag_start[i], width = next_tag_len[i], data = NEXT_TAG_VAL zero-extended.
REQ-022 The memory shall accept the write in that cycle; there is no stall.
REQ-023 When hdr(i) is absent, next_tag_len[i] = 0, or the header is last, TAG(i) shall drive ce=0 and perform no write.
REQ-024 When next_tag_len[i] > 4, the write width shall clamp to 4.
REQ-025 When a write is required but no entry matches, err_o shall set (sticky until the next start) and no write occurs.
REQ-026 TAG0 shall always go to TAG1; TAG1 shall go to DONE with ready_o=1 and ce=0.
REQ-027 Latency: ready_o rises on the 3rd edge after the start edge.
REQ-028 DONE shall hold ready_o and err_o until start_i=0, then return to FREE; ready_o falls on the next start.
REQ-029 mem_we_o shall be 0 whenever mem_ce_o=0.
REQ-030 Any undefined state shall return to FREE.

Reset
REQ-031 While rst=1, asynchronously: ce, we, ready_o, err_o = 0; addr, width, data = 0; config = 0; latched headers = NO_HEADER; state = FREE.
REQ-032 Reset asserted mid-packet shall abort with no further writes; the config must be reloaded after reset.

Verification
REQ-033 Config hdr0: tag start 12, len 2, entry0 = {tag 0x0800, id 1}; headers {0x100, 0x10E}; start -> exactly one write: addr 0x10C, width 2, data 0x0800; ready_o after 3 edges; err_o=0.
REQ-034 Same config with entry0 id 0 and entry1 = {tag 0x86DD, id 1} -> data 0x86DD (entry1 used); with entry0 and entry1 both id 1, entry0 wins.
REQ-035 Headers {0x100, NO_HEADER} -> no write (ce never 1); ready_o=1; err_o=0.
REQ-036 No entry with id 1 -> no write; err_o=1 in DONE; the next start clears err_o.
REQ-037 mod_start_i and start_i high together in FREE -> config written, state stays FREE.
REQ-038 Assert rst during TAG0 -> outputs zero immediately; no write; ready_o=0.

Source files
------------

// File: rtl/deparser_if.sv
// Memory write bus of the deparser.
// The deparser drives one single-cycle write per tagged header onto this bus.
// The memory side has no stall, so every asserted write is accepted in that cycle.
//   mem_ce_o    : memory enable
//   mem_we_o    : write enable (never 1 while mem_ce_o is 0)
//   mem_addr_o  : byte address of the write
//   mem_width_o : write width in bytes (1..4)
//   mem_data_o  : right-aligned write data
// Modports: master (deparser side), slave (memory side).
interface deparser_if;
    localparam int ADDR_BUS   = 32;
    localparam int WORD_WIDTH = 32;

    logic                  mem_ce_o;
    logic                  mem_we_o;
    logic [ADDR_BUS-1:0]   mem_addr_o;
    logic [3:0]            mem_width_o;
    logic [WORD_WIDTH-1:0] mem_data_o;

    modport master (
        output mem_ce_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_width_o,
        output mem_data_o
    );

    modport slave (
        input mem_ce_o,
        input mem_we_o,
        input mem_addr_o,
        input mem_width_o,
        input mem_data_o
    );
endinterface

// File: rtl/deparser.sv
// Deparser: writes the next-header tag of each parsed header back into packet memory.
// For each header i the tag is looked up in next_table[i] by the id of the
// following header and written at hdr(i) addr + next_tag_start[i].
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   start_i              : level request to deparse one packet, held until ready_o
//   parsed_hdrs_i        : {hdr0 addr, hdr1 addr}; NO_HEADER marks an absent header
//   mod_*                : configuration write port (accepted only while idle)
//   mem                  : memory write bus (deparser_if.master)
//   ready_o              : packet done (sticky until the next accepted start)
//   err_o                : a required tag had no table entry (sticky until next start)
// Entry layout: NEXT_TAG_VAL = entry[31:16], NEXT_HDR_ID = entry[15:0].
module deparser (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [63:0] parsed_hdrs_i,
    input  logic        mod_start_i,
    input  logic [31:0] mod_hdr_id_i,
    input  logic [31:0] mod_hdr_len_i,
    input  logic [31:0] mod_next_tag_start_i,
    input  logic [31:0] mod_next_tag_len_i,
    input  logic [63:0] mod_next_table_i,
    deparser_if.master  mem,
    output logic        ready_o,
    output logic        err_o
);
    localparam int          NUM_HEADERS     = 2;
    localparam int          NEXT_TABLE_SIZE = 2;
    localparam int          WORD_WIDTH      = 32;
    localparam logic [31:0] NO_HEADER       = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_TAG0 = 2'd1,
        ST_TAG1 = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // First matching entry wins; result is {hit, NEXT_TAG_VAL}.
    function automatic logic [16:0] lookup(input logic [31:0] e0, input logic [31:0] e1,
                                           input logic [15:0] id);
        logic [16:0] r;
        r = 17'd0;
        if (e0[15:0] == id) begin
            r = {1'b1, e0[31:16]};
        end else if (e1[15:0] == id) begin
            r = {1'b1, e1[31:16]};
        end else begin
            r = 17'd0;
        end
        return r;
    endfunction

    state_t      state_r, next_state_s;
    logic [31:0] hdr_r       [NUM_HEADERS];
    logic [31:0] tag_start_r [NUM_HEADERS];
    logic [31:0] tag_len_r   [NUM_HEADERS];
    logic [31:0] table_r     [NUM_HEADERS][NEXT_TABLE_SIZE];

    logic                  ce_r, we_r, ready_r, err_r;
    logic [31:0]           addr_r;
    logic [3:0]            width_r;
    logic [WORD_WIDTH-1:0] data_r;

    logic        start_accept_s, cfg_write_s;
    logic        idx_s, in_tag_s, last_s, wr_req_s, hit_s;
    logic [15:0] next_id_s, tag_val_s;
    logic [16:0] lookup_s;
    logic [31:0] wr_addr_s;
    logic [3:0]  wr_width_s;

    // The header length belongs to the shared config port but the deparser has no use for it.
    logic unused_hdr_len_s;
    assign unused_hdr_len_s = ^mod_hdr_len_i;

    // Configuration wins over a simultaneous start; ids beyond the header count are ignored.
    assign cfg_write_s    = (state_r == ST_FREE) && mod_start_i && (mod_hdr_id_i[31:1] == 31'd0);
    assign start_accept_s = (state_r == ST_FREE) && start_i && !mod_start_i;

    // Per-header tag decision for the current TAG state.
    always_comb begin
        idx_s      = 1'b0;
        in_tag_s   = 1'b0;
        last_s     = 1'b1;
        next_id_s  = 16'd0;
        lookup_s   = 17'd0;
        hit_s      = 1'b0;
        tag_val_s  = 16'd0;
        wr_req_s   = 1'b0;
        wr_addr_s  = 32'd0;
        wr_width_s = 4'd0;
        if ((state_r == ST_TAG0) || (state_r == ST_TAG1)) begin
            in_tag_s = 1'b1;
            idx_s    = (state_r == ST_TAG1);
        end else begin
            in_tag_s = 1'b0;
        end
        // Only hdr0 can have a successor, and only if hdr1 is present.
        last_s     = idx_s || (hdr_r[1] == NO_HEADER);
        next_id_s  = {15'd0, idx_s} + 16'd1;
        lookup_s   = lookup(table_r[idx_s][0], table_r[idx_s][1], next_id_s);
        hit_s      = lookup_s[16];
        tag_val_s  = lookup_s[15:0];
        wr_req_s   = in_tag_s && !last_s && (hdr_r[idx_s] != NO_HEADER) &&
                     (tag_len_r[idx_s] != 32'd0);
        wr_addr_s  = hdr_r[idx_s] + tag_start_r[idx_s];
        wr_width_s = (tag_len_r[idx_s] > 32'd4) ? 4'd4 : tag_len_r[idx_s][3:0];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FREE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = ST_FREE;
        case (state_r)
            ST_FREE: begin
                if (start_accept_s) begin
                    next_state_s = ST_TAG0;
                end else begin
                    next_state_s = ST_FREE;
                end
            end
            ST_TAG0: next_state_s = ST_TAG1;
            ST_TAG1: next_state_s = ST_DONE;
            ST_DONE: begin
                if (start_i) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FREE;
                end
            end
            default: next_state_s = ST_FREE;
        endcase
    end

    // Per-header configuration storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_HEADERS; i++) begin
                tag_start_r[i] <= 32'd0;
                tag_len_r[i]   <= 32'd0;
                for (int j = 0; j < NEXT_TABLE_SIZE; j++) begin
                    table_r[i][j] <= 32'd0;
                end
            end
        end else if (cfg_write_s) begin
            tag_start_r[mod_hdr_id_i[0]] <= mod_next_tag_start_i;
            tag_len_r[mod_hdr_id_i[0]]   <= mod_next_tag_len_i;
            table_r[mod_hdr_id_i[0]][0]  <= mod_next_table_i[63:32];
            table_r[mod_hdr_id_i[0]][1]  <= mod_next_table_i[31:0];
        end
    end

    // Latch the parsed header addresses when a packet is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_r[0] <= NO_HEADER;
            hdr_r[1] <= NO_HEADER;
        end else if (start_accept_s) begin
            hdr_r[0] <= parsed_hdrs_i[63:32];
            hdr_r[1] <= parsed_hdrs_i[31:0];
        end
    end

    // Registered memory write, ready and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_r    <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            width_r <= 4'd0;
            data_r  <= {WORD_WIDTH{1'b0}};
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (wr_req_s && hit_s) begin
                ce_r    <= 1'b1;
                we_r    <= 1'b1;
                addr_r  <= wr_addr_s;
                width_r <= wr_width_s;
                data_r  <= {16'd0, tag_val_s};
            end else begin
                ce_r    <= 1'b0;
                we_r    <= 1'b0;
                addr_r  <= 32'd0;
                width_r <= 4'd0;
                data_r  <= {WORD_WIDTH{1'b0}};
            end
            if (start_accept_s) begin
                ready_r <= 1'b0;
                err_r   <= 1'b0;
            end else if (state_r == ST_DONE) begin
                ready_r <= 1'b1;
            end else if (wr_req_s && !hit_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign mem.mem_ce_o    = ce_r;
    assign mem.mem_we_o    = we_r;
    assign mem.mem_addr_o  = addr_r;
    assign mem.mem_width_o = width_r;
    assign mem.mem_data_o  = data_r;
    assign ready_o         = ready_r;
    assign err_o           = err_r;
endmodule

// File: tb/tb_deparser.sv
module tb_deparser;
    localparam logic [31:0] NOH = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [63:0] parsed_hdrs_i = 64'd0;
    logic        mod_start_i = 1'b0;
    logic [31:0] mod_hdr_id_i = 32'd0;
    logic [31:0] mod_hdr_len_i = 32'd0;
    logic [31:0] mod_next_tag_start_i = 32'd0;
    logic [31:0] mod_next_tag_len_i = 32'd0;
    logic [63:0] mod_next_table_i = 64'd0;
    logic        ready_o, err_o;

    deparser_if mem_bus ();

    deparser dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_i              (start_i),
        .parsed_hdrs_i        (parsed_hdrs_i),
        .mod_start_i          (mod_start_i),
        .mod_hdr_id_i         (mod_hdr_id_i),
        .mod_hdr_len_i        (mod_hdr_len_i),
        .mod_next_tag_start_i (mod_next_tag_start_i),
        .mod_next_tag_len_i   (mod_next_tag_len_i),
        .mod_next_table_i     (mod_next_table_i),
        .mem                  (mem_bus.master),
        .ready_o              (ready_o),
        .err_o                (err_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference copy of the configuration the bench has written.
    logic [31:0] m_start [2];
    logic [31:0] m_len   [2];
    logic [31:0] m_tab   [2][2];

    // Observations of the last packet.
    int          o_n, o_lat, o_webad;
    logic [31:0] o_addr, o_data;
    logic [3:0]  o_width;
    logic        o_err;

    // Expectations of the reference model.
    int          x_n;
    logic [31:0] x_addr, x_data;
    logic [3:0]  x_width;
    logic        x_err;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_start[i] = 32'd0; m_len[i] = 32'd0; m_tab[i][0] = 32'd0; m_tab[i][1] = 32'd0;
        end
    endtask

    // Expected writes: every present, non-last header with a non-zero tag length
    // writes the tag of the first table entry naming the following header.
    task automatic model(input logic [31:0] h0, input logic [31:0] h1);
        logic [31:0] hd [2];
        hd[0] = h0; hd[1] = h1;
        x_n = 0; x_addr = 32'd0; x_width = 4'd0; x_data = 32'd0; x_err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit last, found;
            logic [15:0] tag;
            last  = (i == 1) || (hd[1] == NOH);
            found = 1'b0;
            tag   = 16'd0;
            if (hd[i] != NOH && m_len[i] != 32'd0 && !last) begin
                for (int j = 0; j < 2; j++) begin
                    if (!found && m_tab[i][j][15:0] == 16'(i + 1)) begin
                        found = 1'b1;
                        tag   = m_tab[i][j][31:16];
                    end
                end
                if (found) begin
                    x_n++;
                    x_addr  = hd[i] + m_start[i];
                    x_width = (m_len[i] > 32'd4) ? 4'd4 : m_len[i][3:0];
                    x_data  = {16'd0, tag};
                end else begin
                    x_err = 1'b1;
                end
            end
        end
    endtask

    task automatic cfg(input int id, input logic [31:0] st, input logic [31:0] len,
                       input logic [31:0] e0, input logic [31:0] e1);
        @(negedge clk);
        mod_start_i = 1'b1; mod_hdr_id_i = 32'(id); mod_hdr_len_i = 32'd20;
        mod_next_tag_start_i = st; mod_next_tag_len_i = len; mod_next_table_i = {e0, e1};
        @(negedge clk);
        mod_start_i = 1'b0;
        m_start[id] = st; m_len[id] = len; m_tab[id][0] = e0; m_tab[id][1] = e1;
    endtask

    // Runs one packet and records what appeared on the bus; latency counts edges from the start edge.
    task automatic do_packet(input logic [31:0] h0, input logic [31:0] h1);
        o_n = 0; o_lat = -1; o_webad = 0; o_addr = 32'd0; o_width = 4'd0; o_data = 32'd0; o_err = 1'b0;
        @(negedge clk);
        start_i = 1'b1; parsed_hdrs_i = {h0, h1};
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            if (!mem_bus.mem_ce_o && mem_bus.mem_we_o) o_webad++;
            if (mem_bus.mem_ce_o) begin
                o_n++;
                o_addr = mem_bus.mem_addr_o; o_width = mem_bus.mem_width_o; o_data = mem_bus.mem_data_o;
            end
            if (ready_o && k > 0) begin
                o_lat = k; o_err = err_o;
                break;
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        model(h0, h1);
    endtask

    task automatic compare_packet(input string nm);
        chk_cnt++; if (o_n !== x_n) $display("FAIL %s writes got %0d exp %0d", nm, o_n, x_n); else pass_cnt++;
        chk_cnt++; if (o_addr !== x_addr) $display("FAIL %s addr got %h exp %h", nm, o_addr, x_addr); else pass_cnt++;
        chk_cnt++; if (o_width !== x_width) $display("FAIL %s width got %0d exp %0d", nm, o_width, x_width); else pass_cnt++;
        chk_cnt++; if (o_data !== x_data) $display("FAIL %s data got %h exp %h", nm, o_data, x_data); else pass_cnt++;
        chk_cnt++; if (o_err !== x_err) $display("FAIL %s err got %b exp %b", nm, o_err, x_err); else pass_cnt++;
        chk_cnt++; if (o_lat !== 3) $display("FAIL %s latency got %0d exp 3", nm, o_lat); else pass_cnt++;
        chk_cnt++; if (o_webad !== 0) $display("FAIL %s we_without_ce got %0d exp 0", nm, o_webad); else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (mem_bus.mem_ce_o !== 1'b0) $display("FAIL rst_ce got %b exp 0", mem_bus.mem_ce_o); else pass_cnt++;
        chk_cnt++; if (mem_bus.mem_we_o !== 1'b0) $display("FAIL rst_we got %b exp 0", mem_bus.mem_we_o); else pass_cnt++;
        chk_cnt++; if (mem_bus.mem_addr_o !== 32'd0) $display("FAIL rst_addr got %h exp 0", mem_bus.mem_addr_o); else pass_cnt++;
        chk_cnt++; if (mem_bus.mem_width_o !== 4'd0) $display("FAIL rst_width got %h exp 0", mem_bus.mem_width_o); else pass_cnt++;
        chk_cnt++; if (mem_bus.mem_data_o !== 32'd0) $display("FAIL rst_data got %h exp 0", mem_bus.mem_data_o); else pass_cnt++;
        chk_cnt++; if (ready_o !== 1'b0) $display("FAIL rst_ready got %b exp 0", ready_o); else pass_cnt++;
        chk_cnt++; if (err_o !== 1'b0) $display("FAIL rst_err got %b exp 0", err_o); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        cfg(0, 32'd12, 32'd2, 32'h0800_0001, 32'h0000_0000);
        do_packet(32'h100, 32'h10E);
        compare_packet("basic");
        chk_cnt++; if (o_addr !== 32'h10C || o_data !== 32'h800) $display("FAIL basic_fixed got %h/%h exp 10c/800", o_addr, o_data); else pass_cnt++;
    endtask

    task automatic test_entry_order();
        cfg(0, 32'd12, 32'd2, 32'h0800_0000, 32'h86DD_0001);
        do_packet(32'h100, 32'h10E);
        compare_packet("entry1");
        chk_cnt++; if (o_data !== 32'h86DD) $display("FAIL entry1_data got %h exp 86dd", o_data); else pass_cnt++;
        cfg(0, 32'd12, 32'd2, 32'h1111_0001, 32'h86DD_0001);
        do_packet(32'h100, 32'h10E);
        compare_packet("entry0_wins");
        chk_cnt++; if (o_data !== 32'h1111) $display("FAIL entry0_wins_data got %h exp 1111", o_data); else pass_cnt++;
    endtask

    task automatic test_absent();
        do_packet(32'h100, NOH);
        compare_packet("hdr1_absent");
        chk_cnt++; if (o_n !== 0) $display("FAIL absent_nowrite got %0d exp 0", o_n); else pass_cnt++;
    endtask

    task automatic test_no_match();
        cfg(0, 32'd4, 32'd3, 32'hAAAA_0000, 32'hBBBB_0002);
        do_packet(32'h200, 32'h220);
        compare_packet("no_match");
        chk_cnt++; if (err_o !== 1'b1) $display("FAIL err_sticky got %b exp 1", err_o); else pass_cnt++;
        cfg(0, 32'd4, 32'd3, 32'hAAAA_0001, 32'hBBBB_0002);
        do_packet(32'h200, 32'h220);
        compare_packet("err_cleared");
    endtask

    task automatic test_width();
        cfg(0, 32'd0, 32'd7, 32'hCAFE_0001, 32'd0);
        do_packet(32'h300, 32'h304);
        compare_packet("clamp");
        chk_cnt++; if (o_width !== 4'd4) $display("FAIL clamp_width got %0d exp 4", o_width); else pass_cnt++;
        cfg(0, 32'd0, 32'd0, 32'hCAFE_0001, 32'd0);
        do_packet(32'h300, 32'h304);
        compare_packet("len_zero");
    endtask

    task automatic test_mod_priority();
        @(negedge clk);
        start_i = 1'b1; parsed_hdrs_i = {32'h400, 32'h410};
        mod_start_i = 1'b1; mod_hdr_id_i = 32'd0; mod_next_tag_start_i = 32'd2;
        mod_next_tag_len_i = 32'd1; mod_next_table_i = {32'h0042_0001, 32'd0};
        @(posedge clk); #1;
        chk_cnt++; if (ready_o !== 1'b1) $display("FAIL mod_prio_stay_free ready got %b exp 1", ready_o); else pass_cnt++;
        chk_cnt++; if (mem_bus.mem_ce_o !== 1'b0) $display("FAIL mod_prio_ce got %b exp 0", mem_bus.mem_ce_o); else pass_cnt++;
        @(negedge clk);
        start_i = 1'b0; mod_start_i = 1'b0;
        m_start[0] = 32'd2; m_len[0] = 32'd1; m_tab[0][0] = 32'h0042_0001; m_tab[0][1] = 32'd0;
        do_packet(32'h400, 32'h410);
        compare_packet("mod_prio_cfg");
    endtask

    task automatic test_random();
        for (int p = 0; p < 30; p++) begin
            logic [31:0] h0, h1, e0, e1;
            e0 = {16'($urandom), 16'($urandom_range(0, 2))};
            e1 = {16'($urandom), 16'($urandom_range(0, 2))};
            cfg(0, $urandom_range(0, 64), $urandom_range(0, 6), e0, e1);
            if ($urandom_range(0, 3) == 0) begin
                cfg(1, $urandom_range(0, 64), $urandom_range(0, 6), {16'($urandom), 16'd2}, 32'($urandom));
            end
            h0 = ($urandom_range(0, 7) == 0) ? NOH : 32'($urandom);
            h1 = ($urandom_range(0, 4) == 0) ? NOH : 32'($urandom);
            do_packet(h0, h1);
            compare_packet("random");
        end
    endtask

    task automatic test_reset_mid();
        int ce_seen;
        ce_seen = 0;
        cfg(0, 32'd8, 32'd2, 32'h0800_0001, 32'd0);
        @(negedge clk);
        start_i = 1'b1; parsed_hdrs_i = {32'h500, 32'h520};
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_cnt++; if (mem_bus.mem_ce_o !== 1'b0) $display("FAIL midrst_ce got %b exp 0", mem_bus.mem_ce_o); else pass_cnt++;
        chk_cnt++; if (ready_o !== 1'b0) $display("FAIL midrst_ready got %b exp 0", ready_o); else pass_cnt++;
        start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (mem_bus.mem_ce_o) ce_seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (mem_bus.mem_ce_o) ce_seen++;
        end
        chk_cnt++; if (ce_seen !== 0) $display("FAIL midrst_nowrite got %0d exp 0", ce_seen); else pass_cnt++;
        do_packet(32'h500, 32'h520);
        compare_packet("after_reset_cfg_cleared");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_entry_order();
        test_absent();
        test_no_match();
        test_width();
        test_mod_priority();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
